// File: rtl/ge_round_driver.sv
// rtl/ge_round_driver.sv - GE judge round driver: latch stimulus, LFSR draw, present round, collect verdict stats.
// Optional LFSR seed loading is enabled by defining GE_SEED_LOAD_EN.
module ge_round_driver #(
    parameter int DRAW_STEPS = 3,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [6:0]       speed_in,
    input  logic [6:0]       effort_in,
    input  logic [4:0]       hard_in,
    input  logic [2:0]       slide_in,
    input  logic [2:0]       timing_in,
    input  logic [1:0]       breakfast_in,
    input  logic [1:0]       movement_in,
    input  logic             weather_in,
`ifdef GE_SEED_LOAD_EN
    input  logic             seed_load,
    input  logic [15:0]      seed,
`endif
    output logic [6:0]       speed,
    output logic [6:0]       effort,
    output logic [4:0]       hard,
    output logic [2:0]       slide,
    output logic [2:0]       timing,
    output logic [1:0]       breakfast,
    output logic [1:0]       movement,
    output logic             weather,
    output logic [6:0]       random1,
    output logic [4:0]       random2,
    output logic [2:0]       luck3,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             res_valid,
    input  logic             res_pass,
    output logic             busy,
    output logic [CNT_W-1:0] rounds,
    output logic [CNT_W-1:0] passes,
    output logic [CNT_W-1:0] streak,
    output logic [CNT_W-1:0] best_streak
);
    localparam logic [15:0] SEED_DEFAULT = 16'hACE1;

    typedef enum logic [1:0] {S_IDLE, S_DRAW, S_PRESENT, S_WAIT_RES} state_t;

    state_t            r_state, w_next;
    logic [15:0]       r_lfsr;
    logic [15:0]       w_lfsr_step;
    logic [3:0]        r_draw_cnt;
    logic              w_last_draw;
    logic              w_seed_load;
    logic [29:0]       r_fields;
    logic [14:0]       r_random;
    logic [CNT_W-1:0]  r_rounds, r_passes, r_streak, r_best;
    logic [CNT_W-1:0]  w_streak_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

`ifdef GE_SEED_LOAD_EN
    assign w_seed_load = seed_load;
`else
    assign w_seed_load = 1'b0;
`endif

    assign w_lfsr_step  = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_last_draw  = (r_draw_cnt == 4'(DRAW_STEPS - 1));
    assign w_streak_inc = sat_inc(r_streak);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (!w_seed_load && start) w_next = S_DRAW;
            S_DRAW:     if (w_last_draw) w_next = S_PRESENT;
            S_PRESENT:  if (out_ready) w_next = S_WAIT_RES;
            S_WAIT_RES: if (res_valid) w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lfsr     <= SEED_DEFAULT;
            r_draw_cnt <= '0;
            r_fields   <= '0;
            r_random   <= '0;
            r_rounds   <= '0;
            r_passes   <= '0;
            r_streak   <= '0;
            r_best     <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
`ifdef GE_SEED_LOAD_EN
                    // A zero seed would lock the LFSR, so substitute the default.
                    if (seed_load)
                        r_lfsr <= (seed == 16'h0000) ? SEED_DEFAULT : seed;
                    else
`endif
                    if (start) begin
                        r_fields   <= {speed_in, effort_in, hard_in, slide_in, timing_in,
                                       breakfast_in, movement_in, weather_in};
                        r_draw_cnt <= '0;
                    end
                end
                S_DRAW: begin
                    r_lfsr     <= w_lfsr_step;
                    r_draw_cnt <= r_draw_cnt + 4'd1;
                    if (w_last_draw)
                        r_random <= {w_lfsr_step[6:0], w_lfsr_step[11:7], w_lfsr_step[14:12]};
                end
                S_WAIT_RES: begin
                    if (res_valid) begin
                        r_rounds <= sat_inc(r_rounds);
                        if (res_pass) begin
                            r_passes <= sat_inc(r_passes);
                            r_streak <= w_streak_inc;
                            if (w_streak_inc > r_best) r_best <= w_streak_inc;
                        end else begin
                            r_streak <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign {speed, effort, hard, slide, timing, breakfast, movement, weather} = r_fields;
    assign {random1, random2, luck3} = r_random;
    assign out_valid   = (r_state == S_PRESENT);
    assign busy        = (r_state != S_IDLE);
    assign rounds      = r_rounds;
    assign passes      = r_passes;
    assign streak      = r_streak;
    assign best_streak = r_best;
endmodule

// File: tb/tb_ge_round_driver.sv
// tb/tb_ge_round_driver.sv - self-checking bench for ge_round_driver (CNT_W=8 and CNT_W=2 instances).
module tb_ge_round_driver;
    localparam int DS = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, out_ready, res_valid, res_pass;
    logic [6:0] speed_in, effort_in;
    logic [4:0] hard_in;
    logic [2:0] slide_in, timing_in;
    logic [1:0] breakfast_in, movement_in;
    logic       weather_in;
`ifdef GE_SEED_LOAD_EN
    logic        seed_load;
    logic [15:0] seed;
`endif

    logic [6:0] speed, effort, random1;
    logic [4:0] hard, random2;
    logic [2:0] slide, timing, luck3;
    logic [1:0] breakfast, movement;
    logic       weather, out_valid, busy;
    logic [7:0] rounds, passes, streak, best_streak;

    logic [6:0] d2_speed, d2_effort, d2_random1;
    logic [4:0] d2_hard, d2_random2;
    logic [2:0] d2_slide, d2_timing, d2_luck3;
    logic [1:0] d2_breakfast, d2_movement;
    logic       d2_weather, d2_out_valid, d2_busy;
    logic [1:0] d2_rounds, d2_passes, d2_streak, d2_best;

    ge_round_driver #(.DRAW_STEPS(DS), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .speed_in(speed_in), .effort_in(effort_in), .hard_in(hard_in), .slide_in(slide_in),
        .timing_in(timing_in), .breakfast_in(breakfast_in), .movement_in(movement_in),
        .weather_in(weather_in),
`ifdef GE_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .speed(speed), .effort(effort), .hard(hard), .slide(slide), .timing(timing),
        .breakfast(breakfast), .movement(movement), .weather(weather),
        .random1(random1), .random2(random2), .luck3(luck3),
        .out_valid(out_valid), .out_ready(out_ready), .res_valid(res_valid), .res_pass(res_pass),
        .busy(busy), .rounds(rounds), .passes(passes), .streak(streak), .best_streak(best_streak)
    );

    ge_round_driver #(.DRAW_STEPS(DS), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start),
        .speed_in(speed_in), .effort_in(effort_in), .hard_in(hard_in), .slide_in(slide_in),
        .timing_in(timing_in), .breakfast_in(breakfast_in), .movement_in(movement_in),
        .weather_in(weather_in),
`ifdef GE_SEED_LOAD_EN
        .seed_load(seed_load), .seed(seed),
`endif
        .speed(d2_speed), .effort(d2_effort), .hard(d2_hard), .slide(d2_slide), .timing(d2_timing),
        .breakfast(d2_breakfast), .movement(d2_movement), .weather(d2_weather),
        .random1(d2_random1), .random2(d2_random2), .luck3(d2_luck3),
        .out_valid(d2_out_valid), .out_ready(out_ready), .res_valid(res_valid), .res_pass(res_pass),
        .busy(d2_busy), .rounds(d2_rounds), .passes(d2_passes), .streak(d2_streak), .best_streak(d2_best)
    );

    typedef struct {
        logic [6:0] speed, effort;
        logic [4:0] hard;
        logic [2:0] slide, timing;
        logic [1:0] breakfast, movement;
        logic       weather;
        logic       pass;
        int         hold;
        bit         early;
        bit         noise;
        int         e_rounds, e_passes, e_streak, e_best;
    } vec_t;

    typedef struct {
        logic [29:0] fields;
        logic [14:0] rnd;
    } exp_round_t;

    exp_round_t  sb_q[$];
    vec_t        tbl[6];
    logic [15:0] m_lfsr;
    int          m_rounds, m_passes, m_streak, m_best;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check_stats(input string tag);
        check({tag, "_rounds"}, 32'(rounds), 32'(sat(m_rounds, 255)));
        check({tag, "_passes"}, 32'(passes), 32'(sat(m_passes, 255)));
        check({tag, "_streak"}, 32'(streak), 32'(sat(m_streak, 255)));
        check({tag, "_best"},   32'(best_streak), 32'(sat(m_best, 255)));
        check({tag, "_d2_rounds"}, 32'(d2_rounds), 32'(sat(m_rounds, 3)));
        check({tag, "_d2_passes"}, 32'(d2_passes), 32'(sat(m_passes, 3)));
        check({tag, "_d2_streak"}, 32'(d2_streak), 32'(sat(m_streak, 3)));
        check({tag, "_d2_best"},   32'(d2_best), 32'(sat(m_best, 3)));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        m_rounds = 0; m_passes = 0; m_streak = 0; m_best = 0;
        sb_q.delete();
    endtask

    task automatic do_round(input vec_t v);
        exp_round_t e, got;
        logic [15:0] l;
        int n;
        @(posedge clk); #1;
        {speed_in, effort_in, hard_in, slide_in, timing_in, breakfast_in, movement_in, weather_in} =
            {v.speed, v.effort, v.hard, v.slide, v.timing, v.breakfast, v.movement, v.weather};
        start = 1'b1;
        l = m_lfsr;
        for (int k = 0; k < DS; k++) l = lstep(l);
        m_lfsr = l;
        e.fields = {v.speed, v.effort, v.hard, v.slide, v.timing, v.breakfast, v.movement, v.weather};
        e.rnd    = {l[6:0], l[11:7], l[14:12]};
        sb_q.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
        {speed_in, effort_in, hard_in, slide_in, timing_in, breakfast_in, movement_in, weather_in} =
            30'($urandom);
        if (v.noise) begin
            start = 1'b1; res_valid = 1'b1; res_pass = 1'b1;
        end
        n = 1;
        while (!out_valid && n < 20) begin
            @(posedge clk); #1;
            start = 1'b0; res_valid = 1'b0;
            n++;
        end
        check("latency", 32'(n), 32'(DS + 1));
        check("busy_present", 32'(busy), 32'd1);
        if (v.noise) check("noise_rounds", 32'(rounds), 32'(sat(m_rounds, 255)));
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        got = sb_q.pop_front();
        check("fields", 32'({speed, effort, hard, slide, timing, breakfast, movement, weather}), 32'(got.fields));
        check("random", 32'({random1, random2, luck3}), 32'(got.rnd));
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_fields", 32'({speed, effort, hard, slide, timing, breakfast, movement, weather,
                                      random1, random2, luck3}), 32'({got.fields, got.rnd}));
        end
        out_ready = 1'b1;
        if (v.early) begin res_valid = 1'b1; res_pass = ~v.pass; end
        @(posedge clk); #1;
        out_ready = 1'b0; res_valid = 1'b0;
        check("valid_drop", 32'(out_valid), 32'd0);
        check("busy_wait", 32'(busy), 32'd1);
        if (v.early) check("early_res_ignored", 32'(rounds), 32'(sat(m_rounds, 255)));
        res_valid = 1'b1; res_pass = v.pass;
        @(posedge clk); #1;
        res_valid = 1'b0;
        m_rounds++;
        if (v.pass) begin
            m_passes++; m_streak++;
            if (m_streak > m_best) m_best = m_streak;
        end else begin
            m_streak = 0;
        end
        check("busy_idle", 32'(busy), 32'd0);
        check_stats("round");
    endtask

    function automatic vec_t mk(input logic p, input int hold, input bit early, input bit noise,
                                input int er, input int ep, input int es, input int eb);
        vec_t v;
        {v.speed, v.effort, v.hard, v.slide, v.timing, v.breakfast, v.movement, v.weather} = 30'($urandom);
        v.pass = p; v.hold = hold; v.early = early; v.noise = noise;
        v.e_rounds = er; v.e_passes = ep; v.e_streak = es; v.e_best = eb;
        return v;
    endfunction

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t v;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; res_valid = 1'b0; res_pass = 1'b0;
        {speed_in, effort_in, hard_in, slide_in, timing_in, breakfast_in, movement_in, weather_in} = '0;
`ifdef GE_SEED_LOAD_EN
        seed_load = 1'b0; seed = '0;
`endif
        do_reset();
        check("reset_outputs", 32'({speed, effort, hard, slide, timing, breakfast, movement, weather}), 32'd0);
        check("reset_random", 32'({random1, random2, luck3}), 32'd0);
        check("reset_valid_busy", 32'({out_valid, busy}), 32'd0);
        check_stats("reset");

        tbl[0] = mk(1'b1, 10, 1'b0, 1'b0, 1, 1, 1, 1);
        tbl[1] = mk(1'b1, 0,  1'b0, 1'b0, 2, 2, 2, 2);
        tbl[2] = mk(1'b0, 0,  1'b1, 1'b0, 3, 2, 0, 2);
        tbl[3] = mk(1'b1, 2,  1'b0, 1'b0, 4, 3, 1, 2);
        tbl[4] = mk(1'b1, 0,  1'b1, 1'b0, 5, 4, 2, 2);
        tbl[5] = mk(1'b1, 0,  1'b0, 1'b0, 6, 5, 3, 3);
        for (int i = 0; i < 6; i++) begin
            do_round(tbl[i]);
            if (i == 0) begin
                check("first_random1", 32'(random1), 32'd28);
                check("first_random2", 32'(random2), 32'd17);
                check("first_luck3", 32'(luck3), 32'd3);
            end
            check("tbl_rounds", 32'(rounds), 32'(tbl[i].e_rounds));
            check("tbl_passes", 32'(passes), 32'(tbl[i].e_passes));
            check("tbl_streak", 32'(streak), 32'(tbl[i].e_streak));
            check("tbl_best", 32'(best_streak), 32'(tbl[i].e_best));
        end

        do_reset();
        for (int i = 0; i < 4; i++) do_round(mk(1'b1, 0, 1'b0, 1'b0, 0, 0, 0, 0));
        check("sat_d2", 32'({d2_rounds, d2_passes, d2_streak, d2_best}), 32'hFF);
        check("sat_d8", 32'({rounds, passes, streak, best_streak}), 32'h04040404);

        do_reset();
        for (int i = 0; i < 2; i++) do_round(mk(1'b1, 0, 1'b0, 1'b0, 0, 0, 0, 0));
        begin
            int n;
            @(posedge clk); #1; start = 1'b1;
            @(posedge clk); #1; start = 1'b0;
            n = 1;
            while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
            check("midreset_present", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
            check("midreset_wait", 32'({out_valid, busy}), 32'd1);
        end
        do_reset();
        check("midreset_outputs", 32'({speed, effort, hard, slide, timing, breakfast, movement, weather}), 32'd0);
        check("midreset_random", 32'(random1), 32'd0);
        check("midreset_busy", 32'({out_valid, busy}), 32'd0);
        check_stats("midreset");
        v = mk(1'b1, 0, 1'b0, 1'b1, 0, 0, 0, 0);
        do_round(v);
        check("postreset_random1", 32'(random1), 32'd28);

`ifdef GE_SEED_LOAD_EN
        do_reset();
        do_round(mk(1'b0, 0, 1'b0, 1'b0, 0, 0, 0, 0));
        @(posedge clk); #1; seed_load = 1'b1; seed = 16'h0000;
        @(posedge clk); #1; seed_load = 1'b0;
        m_lfsr = 16'hACE1;
        do_round(mk(1'b1, 0, 1'b0, 1'b0, 0, 0, 0, 0));
        check("seed0_random1", 32'(random1), 32'd28);
        @(posedge clk); #1; seed_load = 1'b1; seed = 16'h1234; start = 1'b1;
        @(posedge clk); #1; seed_load = 1'b0; start = 1'b0;
        check("seed_start_idle", 32'(busy), 32'd0);
        m_lfsr = 16'h1234;
        do_round(mk(1'b1, 0, 1'b0, 1'b0, 0, 0, 0, 0));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
